// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings: R-type and M-extension funct3 codes, the
// mul/div sequencer state type, and the decoder qualifier for M-extension ops.
package riscv_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FUNCT_W = 3;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] F7_MULDIV  = 7'b0000001;
  localparam logic [OPC_W-1:0] F7_BASE    = 7'b0000000;
  localparam logic [OPC_W-1:0] F7_ALT     = 7'b0100000;

  typedef enum logic [FUNCT_W-1:0] {
    R_ADD_SUB = 3'b000,
    R_SLL     = 3'b001,
    R_SLT     = 3'b010,
    R_SLTU    = 3'b011,
    R_XOR     = 3'b100,
    R_SRL_SRA = 3'b101,
    R_OR      = 3'b110,
    R_AND     = 3'b111
  } r_func;

  typedef enum logic [FUNCT_W-1:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_func;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_CALC  = 2'b01,
    MD_FIXUP = 2'b10,
    MD_DONE  = 2'b11
  } muldiv_state_t;

  // Decoder qualifier: only OP with funct7=0000001 goes to the mul/div unit.
  function automatic logic muldiv_start(input logic            valid,
                                        input logic [OPC_W-1:0] opcode,
                                        input logic [OPC_W-1:0] funct7);
    return valid && (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  endfunction

  // Everything else of opcode OP is handled by the R-type ALU.
  function automatic logic alu_r_start(input logic            valid,
                                       input logic [OPC_W-1:0] opcode,
                                       input logic [OPC_W-1:0] funct7);
    return valid && (opcode == OPC_OP) && (funct7 != F7_MULDIV);
  endfunction

endpackage

// File: rtl/rv_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: one prep cycle, XLEN shift-add or
// restoring shift-subtract iterations on magnitudes, then a sign-fixup cycle.
module rv_muldiv_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned AW    = XLEN + 2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  XMIN      = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  m_func           func_q, func_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] mag_q, mag_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            is_div;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   alu_a, alu_b;
  logic            alu_cin;
  logic [AW-1:0]   alu_sum;
  logic [PW-1:0]   prod_step;
  logic [PW-1:0]   prod_neg;
  logic [XLEN-1:0] quo, rem;
  logic [XLEN-1:0] fix_result;

  logic            acc_div_zero, acc_ovf;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // Operand signedness and magnitudes from the latched request.
  always_comb begin
    is_div  = func_q[2];
    rs1_neg = ((func_q == M_MULH) || (func_q == M_MULHSU) ||
               (func_q == M_DIV)  || (func_q == M_REM)) && rs1_q[XLEN-1];
    rs2_neg = ((func_q == M_MULH) || (func_q == M_DIV) ||
               (func_q == M_REM)) && rs2_q[XLEN-1];
    mag1    = rs1_neg ? (XLEN'(0) - rs1_q) : rs1_q;
    mag2    = rs2_neg ? (XLEN'(0) - rs2_q) : rs2_q;
  end

  // Shared 33-bit adder: add for multiply, subtract (carry = no borrow) for divide.
  always_comb begin
    if (is_div) begin
      alu_a   = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
      alu_b   = ~{1'b0, mag_q};
      alu_cin = 1'b1;
    end else begin
      alu_a   = {1'b0, prod_q[PW-1:XLEN]};
      alu_b   = {1'b0, mag_q};
      alu_cin = 1'b0;
    end
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + AW'(alu_cin);
  end

  // One iteration: right-shifting product, or left-shifting remainder/quotient.
  always_comb begin
    if (is_div) begin
      if (alu_sum[XLEN+1]) begin
        prod_step = {alu_sum[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
      end else begin
        prod_step = {alu_a[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (prod_q[0]) begin
        prod_step = {alu_sum[XLEN:0], prod_q[XLEN-1:1]};
      end else begin
        prod_step = {1'b0, prod_q[PW-1:1]};
      end
    end
  end

  // Sign correction and high/low selection applied in the FIXUP cycle.
  always_comb begin
    prod_neg = PW'(0) - prod_q;
    quo      = prod_q[XLEN-1:0];
    rem      = prod_q[PW-1:XLEN];
    case (func_q)
      M_MUL: fix_result = prod_q[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU:
        fix_result = (rs1_neg ^ rs2_neg) ? prod_neg[PW-1:XLEN] : prod_q[PW-1:XLEN];
      M_DIV, M_DIVU:
        fix_result = (rs1_neg ^ rs2_neg) ? (XLEN'(0) - quo) : quo;
      default:
        fix_result = rs1_neg ? (XLEN'(0) - rem) : rem;
    endcase
  end

  // Cases that resolve without iterating: divide by zero and signed overflow.
  always_comb begin
    acc_div_zero = funct3[2] && (rs2 == '0);
    acc_ovf      = funct3[2] && !funct3[0] && (rs1 == XMIN) && (rs2 == '1);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    mag_d    = mag_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (start) begin
          func_d = m_func'(funct3);
          rs1_d  = rs1;
          rs2_d  = rs2;
          cnt_d  = '0;
          prod_d = '0;
          if (acc_div_zero) begin
            result_d = funct3[1] ? rs1 : '1;
            state_d  = MD_DONE;
          end else if (acc_ovf) begin
            result_d = funct3[1] ? '0 : rs1;
            state_d  = MD_DONE;
          end else begin
            state_d  = MD_CALC;
          end
        end
      end

      MD_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '0) begin
          mag_d  = is_div ? mag2 : mag1;
          prod_d = {XLEN'(0), (is_div ? mag1 : mag2)};
        end else begin
          prod_d = prod_step;
          if (cnt_q == LAST_ITER) begin
            state_d = MD_FIXUP;
          end
        end
      end

      MD_FIXUP: begin
        result_d = fix_result;
        state_d  = MD_DONE;
      end

      default: state_d = MD_IDLE;
    endcase

    busy_d = (state_d == MD_CALC) || (state_d == MD_FIXUP);
    done_d = (state_d == MD_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      func_q   <= M_MUL;
      rs1_q    <= '0;
      rs2_q    <= '0;
      mag_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      mag_q    <= mag_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/rv_muldiv_ctrl.md
RV_MULDIV_CTRL -- requirements
Module: rv_muldiv_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin an operation.
REQ-005 SHALL have port funct3, input, 3, selecting the M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1, input, XLEN, the multiplicand or dividend.
REQ-007 SHALL have port rs2, input, XLEN, the multiplier or divisor.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, XLEN, the rd value, held stable from done until the next accepted start.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-012 SHALL accept start only in IDLE or DONE, latching funct3, rs1 and rs2 at that edge; start in CALC or FIXUP is ignored.
REQ-013 On accept, SHALL go to CALC with busy=1, unless a special case of REQ-019 or REQ-020 applies, in which case it goes directly to DONE.
REQ-014 CALC SHALL run exactly XLEN iterations counted by a 6-bit counter: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-015 After the last iteration, SHALL spend one FIXUP cycle applying sign correction and high/low selection, then enter DONE.
REQ-016 Normal latency SHALL be XLEN+2 cycles from the accepting edge to the edge that asserts done, i.e. 34 cycles.
REQ-017 DONE SHALL last one cycle (done=1, busy=0), then return to IDLE; start asserted during DONE is accepted back-to-back.
REQ-018 Multiply results: MUL gives the low XLEN bits; MULH gives the high bits of signed×signed; MULHSU gives the high bits of signed rs1 × unsigned rs2; MULHU gives the high bits of unsigned×unsigned.
REQ-019 Division by zero SHALL give DIV/DIVU = all ones and REM/REMU = rs1, with latency 1 (done on the cycle after accept).
REQ-020 Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0, with latency 1.
REQ-021 DIV SHALL truncate toward zero; REM SHALL take the sign of the dividend.
REQ-022 The internal product SHALL be 2*XLEN wide; no intermediate value is truncated before FIXUP.
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 rst SHALL force IDLE, busy=0, done=0, result=0, and clear counter and operand registers.
REQ-025 rst during CALC or FIXUP SHALL abort the operation with no done pulse; start sampled in the reset cycle is ignored.
REQ-026 rst SHALL have priority over start in the same cycle.

Structure
REQ-027 The m_func enum (funct3 encodings) and the muldiv_state_t enum SHALL live in riscv_pkg alongside r_func.
REQ-028 SHALL be a single module with no sub-module; the FSM, counter, and shared 33-bit add/subtract datapath are all in one file.
REQ-029 The decoder SHALL raise start only for opcode OP with funct7 = 0000001; the R-type ALU handles all other funct7 values.

Verification
REQ-030 MUL rs1=7, rs2=6 -> done exactly 34 cycles after accept, result=0x0000002A.
REQ-031 MULH rs1=0x80000000, rs2=0x80000000 -> result=0x40000000; MULHU with 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU with rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
REQ-032 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIVU and REMU with rs2=0, rs1=0x1234 -> done one cycle after accept with 0xFFFFFFFF and 0x00001234 respectively; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000 in 1 cycle.
REQ-034 start pulsed at cycles 5 and 20 of a running MUL -> both ignored, single done, result unchanged; start during DONE -> new op accepted with no idle gap.
REQ-035 rst asserted at iteration 10 of a DIV -> next cycle busy=0, done=0, result=0, no done pulse follows; a subsequent MUL 3×3 gives 9.
